// File: rtl/odu_chan_sched.sv
// ODU channel scheduler.
// A round-robin scheduler grants one enabled channel a full row of 384-bit
// word slots, then moves on to the next enabled channel. Each channel keeps
// its own row-within-frame counter, which drives the frame/row start flags.
// Configuration uses a small synchronous chip-select bus.
module odu_chan_sched #(
  parameter int NUM_CH         = 8,
  parameter int WORDS_PER_ROW  = 85,
  parameter int ROWS_PER_FRAME = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_n_cs,
  input  logic        cfg_n_we,
  input  logic        cfg_n_oe,
  input  logic [3:0]  cfg_addr,
  input  logic [15:0] cfg_din,
  output logic [15:0] cfg_dout,
  input  logic        gen_ready,
  output logic        sched_valid,
  output logic [6:0]  sched_chid,
  output logic        sched_fs_start,
  output logic        sched_rs_start
);

  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WORD_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam int ROW_W  = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_BURST  = 2'd2
  } state_t;

  // Configuration registers
  logic              wr_active;
  logic              wr_prev_reg;
  logic              wr_stb;
  logic              soft_clear_now;
  logic              enable_reg;
  logic              soft_clear_reg;
  logic [NUM_CH-1:0] ch_en_reg;
  logic [6:0]        chid_base_reg;
  logic [15:0]       frame_cnt_reg;
  logic [15:0]       rd_data;
  logic              ch_en_any;

  // Scheduler state
  state_t            state_reg;
  state_t            state_next;
  logic [IDX_W-1:0]  rr_ptr_reg;
  logic [IDX_W-1:0]  cur_idx_reg;
  logic [IDX_W-1:0]  pick_idx;
  logic [6:0]        chid_reg;
  logic [WORD_W-1:0] word_cnt_reg;
  logic [ROW_W-1:0]  row_cnt_reg [NUM_CH];
  logic [ROW_W-1:0]  cur_row;
  logic              xfer;
  logic              row_end;
  logic              row_wrap;

  // Upper data bits are not stored by every register; fold them away.
  logic unused_din;
  assign unused_din = ^cfg_din;

  // A write strobe is the first edge of a cs/we-low window.
  assign wr_active      = ~cfg_n_cs & ~cfg_n_we;
  assign wr_stb         = wr_active & ~wr_prev_reg;
  assign soft_clear_now = wr_stb && (cfg_addr == 4'd0) && cfg_din[1];
  assign ch_en_any      = |ch_en_reg;

  // Config register writes and the self-clearing soft_clear flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_prev_reg    <= 1'b0;
      enable_reg     <= 1'b0;
      soft_clear_reg <= 1'b0;
      ch_en_reg      <= '0;
      chid_base_reg  <= '0;
    end else begin
      wr_prev_reg    <= wr_active;
      soft_clear_reg <= soft_clear_now;
      if (wr_stb) begin
        case (cfg_addr)
          4'd0:    enable_reg    <= cfg_din[0];
          4'd1:    ch_en_reg     <= cfg_din[NUM_CH-1:0];
          4'd2:    chid_base_reg <= cfg_din[6:0];
          default: ;
        endcase
      end
    end
  end

  // Read multiplexer for the addressed register
  always_comb begin
    rd_data = 16'h0000;
    case (cfg_addr)
      4'd0: rd_data = {14'd0, soft_clear_reg, enable_reg};
      4'd1: rd_data = 16'(ch_en_reg);
      4'd2: rd_data = {9'd0, chid_base_reg};
      4'd3: rd_data = {9'd0, 3'(cur_idx_reg), 3'd0, (state_reg != ST_IDLE)};
      4'd4: rd_data = frame_cnt_reg;
      default: rd_data = 16'h0000;
    endcase
  end

  // Registered read data, zero whenever the bus is not reading
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_dout <= 16'h0000;
    end else if (!cfg_n_cs && !cfg_n_oe) begin
      cfg_dout <= rd_data;
    end else begin
      cfg_dout <= 16'h0000;
    end
  end

  // Round-robin search: first enabled channel at or after rr_ptr_reg
  always_comb begin
    int  cand;
    logic found;
    cand     = 0;
    found    = 1'b0;
    pick_idx = rr_ptr_reg;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (!found && ch_en_reg[cand]) begin
        pick_idx = IDX_W'(cand);
        found    = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // FSM next-state logic; soft_clear aborts from any state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (enable_reg && ch_en_any) state_next = ST_SELECT;
      ST_SELECT: state_next = (enable_reg && ch_en_any) ? ST_BURST : ST_IDLE;
      ST_BURST:  if (row_end) state_next = enable_reg ? ST_SELECT : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    if (soft_clear_now) state_next = ST_IDLE;
  end

  // FSM outputs: slot grant and row/frame start flags
  always_comb begin
    sched_valid    = (state_reg == ST_BURST);
    sched_rs_start = sched_valid && (word_cnt_reg == '0);
    sched_fs_start = sched_rs_start && (cur_row == '0);
    sched_chid     = chid_reg;
  end

  assign cur_row  = row_cnt_reg[cur_idx_reg];
  assign xfer     = sched_valid & gen_ready;
  assign row_end  = xfer && (word_cnt_reg == WORD_W'(WORDS_PER_ROW - 1));
  assign row_wrap = (cur_row == ROW_W'(ROWS_PER_FRAME - 1));

  // Channel selection, grant ID and word counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_reg   <= '0;
      cur_idx_reg  <= '0;
      chid_reg     <= '0;
      word_cnt_reg <= '0;
    end else if (soft_clear_now) begin
      rr_ptr_reg   <= '0;
      cur_idx_reg  <= '0;
      word_cnt_reg <= '0;
    end else begin
      if (state_reg == ST_SELECT && state_next == ST_BURST) begin
        cur_idx_reg <= pick_idx;
        chid_reg    <= chid_base_reg + 7'(pick_idx);
        rr_ptr_reg  <= (pick_idx == IDX_W'(NUM_CH - 1)) ? '0 : pick_idx + 1'b1;
      end
      if (xfer) word_cnt_reg <= row_end ? '0 : word_cnt_reg + 1'b1;
    end
  end

  // Frame counter counts completed frames across all channels
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     frame_cnt_reg <= 16'h0000;
    else if (soft_clear_now)      frame_cnt_reg <= 16'h0000;
    else if (row_end && row_wrap) frame_cnt_reg <= frame_cnt_reg + 16'h0001;
  end

  // Independent row-within-frame counter per channel
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_row
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          row_cnt_reg[gi] <= '0;
        end else if (soft_clear_now) begin
          row_cnt_reg[gi] <= '0;
        end else if (row_end && (cur_idx_reg == IDX_W'(gi))) begin
          row_cnt_reg[gi] <= row_wrap ? '0 : row_cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_odu_chan_sched.sv
// Testbench for odu_chan_sched: a row-level reference model predicts every
// granted word into a queue; a negedge monitor compares the DUT against it.
module tb_odu_chan_sched;

  localparam int NUM_CH = 8;
  localparam int WPR    = 85;
  localparam int RPF    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_n_cs, cfg_n_we, cfg_n_oe;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_din;
  logic [15:0] cfg_dout;
  logic        gen_ready;
  logic        sched_valid;
  logic [6:0]  sched_chid;
  logic        sched_fs_start;
  logic        sched_rs_start;

  int checks = 0;
  int errors = 0;
  bit ready_rand = 1'b0;

  typedef struct {
    logic [6:0] chid;
    logic       fs;
    logic       rs;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state
  int         m_rr;
  int         m_last;
  int         m_frame;
  int         m_row [NUM_CH];
  logic [7:0] m_ch_en;
  logic [6:0] m_base;

  odu_chan_sched #(
    .NUM_CH(NUM_CH), .WORDS_PER_ROW(WPR), .ROWS_PER_FRAME(RPF)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_n_cs(cfg_n_cs), .cfg_n_we(cfg_n_we), .cfg_n_oe(cfg_n_oe),
    .cfg_addr(cfg_addr), .cfg_din(cfg_din), .cfg_dout(cfg_dout),
    .gen_ready(gen_ready),
    .sched_valid(sched_valid), .sched_chid(sched_chid),
    .sched_fs_start(sched_fs_start), .sched_rs_start(sched_rs_start)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    m_rr = 0;
    m_last = 0;
    m_frame = 0;
    for (int i = 0; i < NUM_CH; i++) m_row[i] = 0;
  endfunction

  // Predict n whole rows: round-robin pick, then WPR word slots for it
  function automatic void predict_rows(int n);
    for (int r = 0; r < n; r++) begin
      int idx = -1;
      for (int k = 0; k < NUM_CH; k++) begin
        int c = (m_rr + k) % NUM_CH;
        if (idx < 0 && m_ch_en[c]) idx = c;
      end
      m_rr = (idx + 1) % NUM_CH;
      m_last = idx;
      for (int w = 0; w < WPR; w++) begin
        exp_t e;
        e.chid = 7'((int'(m_base) + idx) % 128);
        e.rs   = (w == 0);
        e.fs   = (w == 0) && (m_row[idx] == 0);
        exp_q.push_back(e);
      end
      m_row[idx] = (m_row[idx] + 1) % RPF;
      if (m_row[idx] == 0) m_frame = (m_frame + 1) % 65536;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, req);
    end
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    cfg_n_cs = 1'b0; cfg_n_we = 1'b0; cfg_addr = a; cfg_din = d;
    @(posedge clk); #1;
    cfg_n_cs = 1'b1; cfg_n_we = 1'b1;
  endtask

  task automatic cfg_read(input logic [3:0] a, output logic [15:0] d);
    @(posedge clk); #1;
    cfg_n_cs = 1'b0; cfg_n_oe = 1'b0; cfg_addr = a;
    @(posedge clk); #1;
    d = cfg_dout;
    cfg_n_cs = 1'b1; cfg_n_oe = 1'b1;
  endtask

  task automatic wait_q_le(input int n, input string tag);
    int cyc = 0;
    while (exp_q.size() > n && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    checks++;
    if (exp_q.size() > n) begin
      errors++;
      $display("FAIL %s_timeout: got queue=%0d required<=%0d", tag, exp_q.size(), n);
    end
  endtask

  task automatic drain_and_check(input string tag);
    logic [15:0] d;
    wait_q_le(0, tag);
    repeat (4) @(posedge clk);
    cfg_read(4'd4, d);
    check({tag, "_frame_cnt"}, 32'(d), 32'(m_frame));
    cfg_read(4'd3, d);
    check({tag, "_status"}, 32'(d), 32'((m_last % 8) << 4));
  endtask

  // Ready generator: always-ready or random back-pressure
  initial begin
    gen_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      gen_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: each valid cycle must match the queue head; pop on transfer
  always @(negedge clk) begin
    if (rst && sched_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_grant: got chid=0x%0h required no grant", sched_chid);
      end else begin
        if (sched_chid !== exp_q[0].chid || sched_fs_start !== exp_q[0].fs ||
            sched_rs_start !== exp_q[0].rs) begin
          errors++;
          $display("FAIL grant: got chid=0x%0h fs=%b rs=%b required chid=0x%0h fs=%b rs=%b",
                   sched_chid, sched_fs_start, sched_rs_start,
                   exp_q[0].chid, exp_q[0].fs, exp_q[0].rs);
        end
        if (gen_ready) begin
          if (exp_q[0].rs)
            $display("row start chid=0x%0h fs=%b t=%0t", exp_q[0].chid, exp_q[0].fs, $time);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [15:0] d;
    rst = 1'b0;
    cfg_n_cs = 1'b1; cfg_n_we = 1'b1; cfg_n_oe = 1'b1;
    cfg_addr = 4'd0; cfg_din = 16'h0000;
    model_clear();
    m_ch_en = 8'h00; m_base = 7'h00;

    // Reset state
    repeat (3) @(posedge clk); #1;
    check("rst_valid", 32'(sched_valid), 0);
    check("rst_fs", 32'(sched_fs_start), 0);
    check("rst_rs", 32'(sched_rs_start), 0);
    check("rst_chid", 32'(sched_chid), 0);
    check("rst_dout", 32'(cfg_dout), 0);
    #2 rst = 1'b1;
    for (int a = 0; a < 6; a++) begin
      cfg_read(4'(a), d);
      check($sformatf("rst_reg%0d", a), 32'(d), 0);
    end

    // Alternating channels 0x10/0x12, full ready, latency check
    cfg_write(4'd2, 16'h0010); m_base = 7'h10;
    cfg_write(4'd1, 16'h0005); m_ch_en = 8'h05;
    predict_rows(8);
    cfg_write(4'd0, 16'h0001);
    check("lat_c0", 32'(sched_valid), 0);
    @(posedge clk); #1;
    check("lat_c1", 32'(sched_valid), 0);
    @(posedge clk); #1;
    check("lat_c2", 32'(sched_valid), 1);
    wait_q_le(45, "alt");
    cfg_write(4'd0, 16'h0000);
    drain_and_check("alt");

    // Random channel set and base with random back-pressure
    ready_rand = 1'b1;
    m_ch_en = 8'($urandom_range(1, 255));
    m_base  = 7'($urandom_range(0, 127));
    cfg_write(4'd2, 16'(m_base));
    cfg_write(4'd1, 16'(m_ch_en));
    predict_rows(6);
    cfg_write(4'd0, 16'h0001);
    wait_q_le(45, "rand");
    cfg_write(4'd0, 16'h0000);
    drain_and_check("rand");

    // Enable cleared mid-row: the row still completes
    cfg_write(4'd1, 16'h0001); m_ch_en = 8'h01;
    predict_rows(1);
    cfg_write(4'd0, 16'h0001);
    wait_q_le(45, "en_clr");
    cfg_write(4'd0, 16'h0000);
    drain_and_check("en_clr");

    // Soft clear mid-row, enable kept: restart from index 0 with fs
    ready_rand = 1'b0;
    cfg_write(4'd1, 16'h0005); m_ch_en = 8'h05;
    predict_rows(1);
    cfg_write(4'd0, 16'h0001);
    wait_q_le(65, "sclr");
    cfg_write(4'd0, 16'h0003);
    check("sclr_valid", 32'(sched_valid), 0);
    exp_q.delete();
    model_clear();
    predict_rows(2);
    cfg_read(4'd4, d);
    check("sclr_frame_cnt", 32'(d), 32'(m_frame));
    wait_q_le(45, "sclr2");
    cfg_write(4'd0, 16'h0000);
    drain_and_check("sclr");

    // 7-bit chid wrap, CH_EN cleared mid-row
    ready_rand = 1'b1;
    cfg_write(4'd2, 16'h007F); m_base = 7'h7F;
    cfg_write(4'd1, 16'h0081); m_ch_en = 8'h81;
    predict_rows(4);
    cfg_write(4'd0, 16'h0001);
    wait_q_le(45, "wrap");
    cfg_write(4'd1, 16'h0000); m_ch_en = 8'h00;
    drain_and_check("wrap");
    cfg_write(4'd0, 16'h0000);

    // Reset mid-burst
    cfg_write(4'd2, 16'h0022); m_base = 7'h22;
    cfg_write(4'd1, 16'h0005); m_ch_en = 8'h05;
    predict_rows(3);
    cfg_write(4'd0, 16'h0001);
    wait_q_le(200, "mid_rst");
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("mrst_valid", 32'(sched_valid), 0);
    check("mrst_fs", 32'(sched_fs_start), 0);
    check("mrst_rs", 32'(sched_rs_start), 0);
    check("mrst_chid", 32'(sched_chid), 0);
    check("mrst_dout", 32'(cfg_dout), 0);
    exp_q.delete();
    model_clear();
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    for (int a = 0; a < 5; a++) begin
      cfg_read(4'(a), d);
      check($sformatf("mrst_reg%0d", a), 32'(d), 0);
    end
    repeat (10) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
